// File: rtl/led_sequence_player_if.sv
// Handshake/bus bundle between the game controller and the LED sequence player.
//   master : game controller side (drives start/abort/length/pattern, reads status + LEDs)
//   slave  : player side (reads the request, drives busy/done/index and the 4 LEDs)
// Ports carried:
//   i_Start, i_Abort         request controls
//   i_Length [3:0]           entries to play (clamped to MAX_LEN by the player)
//   i_Pattern[2*MAX_LEN-1:0] entry k = i_Pattern[2k+1:2k]
//   o_Busy, o_Done           playback status, done is a one-cycle pulse
//   o_Index [3:0]            entry being played, 0 when not playing
//   o_LED_1..o_LED_4         one-hot LED drive
interface led_sequence_player_if #(
    parameter int MAX_LEN = 11
);
    logic                   i_Start;
    logic                   i_Abort;
    logic [3:0]             i_Length;
    logic [2*MAX_LEN-1:0]   i_Pattern;
    logic                   o_Busy;
    logic                   o_Done;
    logic [3:0]             o_Index;
    logic                   o_LED_1;
    logic                   o_LED_2;
    logic                   o_LED_3;
    logic                   o_LED_4;

    modport master (
        output i_Start, i_Abort, i_Length, i_Pattern,
        input  o_Busy, o_Done, o_Index, o_LED_1, o_LED_2, o_LED_3, o_LED_4
    );

    modport slave (
        input  i_Start, i_Abort, i_Length, i_Pattern,
        output o_Busy, o_Done, o_Index, o_LED_1, o_LED_2, o_LED_3, o_LED_4
    );
endinterface

// File: rtl/led_sequence_player.sv
// Plays a latched sequence of 2-bit LED codes onto four one-hot LEDs.
// Each entry is shown as an OFF phase followed by an ON phase, each lasting
// CLKS_PER_STEP cycles. Start/busy/done handshake with abort.
// Ports:
//   i_Clk    system clock
//   i_Reset  synchronous, active-high reset
//   bus      led_sequence_player_if.slave (start/abort/length/pattern in,
//            busy/done/index/LEDs out)
// All outputs come straight from flops; nothing combinational from inputs.
module led_sequence_player #(
    parameter int CLKS_PER_STEP = 6250000,
    parameter int MAX_LEN       = 11
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    led_sequence_player_if.slave  bus
);

    localparam int              CNT_W  = $clog2(CLKS_PER_STEP);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CLKS_PER_STEP - 1);
    localparam logic [3:0]      LEN_MAX = 4'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_OFF, S_ON, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q,   cnt_d;
    logic [3:0]               idx_q,   idx_d;
    logic [3:0]               len_q,   len_d;
    logic [MAX_LEN-1:0][1:0]  pat_q,   pat_d;
    logic                     busy_q,  busy_d;
    logic                     done_q,  done_d;
    logic [3:0]               led_q,   led_d;

    logic [3:0] len_eff;
    logic [1:0] cur_code;
    logic       cnt_tc;

    assign len_eff  = (bus.i_Length > LEN_MAX) ? LEN_MAX : bus.i_Length;
    assign cur_code = pat_q[idx_q];
    assign cnt_tc   = (cnt_q == CNT_TC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pat_d   = pat_q;
        busy_d  = busy_q;
        led_d   = led_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Start wins over abort here; abort only acts once busy.
                if (bus.i_Start) begin
                    pat_d = bus.i_Pattern;
                    len_d = len_eff;
                    cnt_d = '0;
                    idx_d = 4'd0;
                    led_d = 4'b0000;
                    if (len_eff == 4'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_OFF;
                        busy_d  = 1'b1;
                    end
                end
            end

            S_OFF, S_ON: begin
                if (bus.i_Abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                    busy_d  = 1'b0;
                    led_d   = 4'b0000;
                end else if (!cnt_tc) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (state_q == S_OFF) begin
                    // LED is loaded together with the state so it is lit
                    // exactly during the ON phase.
                    cnt_d   = '0;
                    state_d = S_ON;
                    led_d   = 4'b0001 << cur_code;
                end else begin
                    cnt_d = '0;
                    led_d = 4'b0000;
                    if (idx_q == len_q - 4'd1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        idx_d   = 4'd0;
                    end else begin
                        state_d = S_OFF;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end

            S_DONE: begin
                // Start is deliberately ignored for this one cycle.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                idx_d   = 4'd0;
                led_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            len_q   <= 4'd0;
            pat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            led_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            led_q   <= led_d;
        end
    end

    assign bus.o_Busy  = busy_q;
    assign bus.o_Done  = done_q;
    assign bus.o_Index = idx_q;
    assign bus.o_LED_1 = led_q[0];
    assign bus.o_LED_2 = led_q[1];
    assign bus.o_LED_3 = led_q[2];
    assign bus.o_LED_4 = led_q[3];

endmodule

// File: tb/tb_led_sequence_player.sv
module tb_led_sequence_player;

    localparam int CPS     = 4;
    localparam int MAX_LEN = 11;

    localparam int M_NORM  = 0;
    localparam int M_DIST  = 1;
    localparam int M_ABORT = 2;
    localparam int M_RST   = 3;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    led_sequence_player_if #(.MAX_LEN(MAX_LEN)) bus ();

    led_sequence_player #(
        .CLKS_PER_STEP (CPS),
        .MAX_LEN       (MAX_LEN)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output vector: {busy, done, index[3:0], LED_4..LED_1}
    function automatic logic [9:0] observe();
        return {bus.o_Busy, bus.o_Done, bus.o_Index,
                bus.o_LED_4, bus.o_LED_3, bus.o_LED_2, bus.o_LED_1};
    endfunction

    // Timeline model: c is the cycle number after the accepting edge (1-based).
    // Entry k occupies busy cycles 2*CPS*k+1 .. 2*CPS*(k+1); its second half lights the LED.
    function automatic logic [9:0] model(int c, int len, logic [2*MAX_LEN-1:0] pat);
        int         k;
        int         ph;
        int         code;
        logic [3:0] led;
        if (len == 0) return (c == 1) ? 10'b01_0000_0000 : 10'd0;
        if (c >= 1 && c <= 2 * CPS * len) begin
            k    = (c - 1) / (2 * CPS);
            ph   = (c - 1) % (2 * CPS);
            code = int'((pat >> (2 * k)) & 22'd3);
            led  = (ph >= CPS) ? (4'b0001 << code) : 4'b0000;
            return {1'b1, 1'b0, 4'(k), led};
        end
        if (c == 2 * CPS * len + 1) return 10'b01_0000_0000;
        return 10'd0;
    endfunction

    task automatic check(input string tag, input int c, input logic [9:0] obs, input logic [9:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, exp);
    endtask

    // Start one playback and check every cycle up to done plus a tail.
    // mode selects a disturbance applied right after checking cycle ev_c.
    task automatic run(input string tag, input logic [2*MAX_LEN-1:0] pat, input logic [3:0] len_in,
                       input int mode, input int ev_c, input int tail);
        int len;
        int last;
        int cut;
        len  = (int'(len_in) > MAX_LEN) ? MAX_LEN : int'(len_in);
        last = (len == 0) ? 1 : 2 * CPS * len + 1;
        cut  = (mode == M_ABORT || mode == M_RST) ? ev_c : 32'h3fff_ffff;
        @(negedge clk);
        bus.i_Pattern = pat;
        bus.i_Length  = len_in;
        bus.i_Start   = 1'b1;
        @(posedge clk);
        #1 bus.i_Start = 1'b0;
        for (int c = 1; c <= last + tail; c++) begin
            @(negedge clk);
            check(tag, c, observe(), (c > cut) ? 10'd0 : model(c, len, pat));
            if (mode == M_DIST && c == 10) begin
                bus.i_Start   = 1'b1;
                bus.i_Pattern = 22'($urandom);
                bus.i_Length  = 4'($urandom);
            end
            if (mode == M_ABORT && c == ev_c) bus.i_Abort = 1'b1;
            if (mode == M_RST   && c == ev_c) rst = 1'b1;
            if (c == ev_c + 1) begin
                bus.i_Start = 1'b0;
                bus.i_Abort = 1'b0;
                rst         = 1'b0;
            end
        end
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.i_Start   = 1'b0;
        bus.i_Abort   = 1'b0;
        bus.i_Length  = 4'd0;
        bus.i_Pattern = '0;

        // Reset, then idle with no start
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", 0, observe(), 10'd0);
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check("idle", c, observe(), 10'd0);
        end

        // Basic play: entries 10, 01, 11
        run("basic", 22'b11_01_10, 4'd3, M_NORM, 0, 5);

        // Zero length: done only
        run("len0", 22'($urandom), 4'd0, M_NORM, 0, 5);

        // Length clamp to MAX_LEN
        run("len15", 22'($urandom), 4'd15, M_NORM, 0, 4);

        // Randomized playbacks
        for (int i = 0; i < 4; i++)
            run("rand", 22'($urandom), 4'($urandom_range(1, 15)), M_NORM, 0, 2);

        // Restart and input changes during play are ignored
        run("ignore", 22'($urandom), 4'd2, M_DIST, 10, 20);

        // Abort in ON phase of entry 1, then a normal replay
        run("abort", 22'($urandom), 4'd3, M_ABORT, 14, 20);
        run("after_abort", 22'($urandom), 4'd2, M_NORM, 0, 2);

        // Reset in busy cycle 7
        run("mid_reset", 22'($urandom), 4'd3, M_RST, 7, 10);

        // Simultaneous start and reset stays idle
        @(negedge clk);
        bus.i_Pattern = 22'($urandom);
        bus.i_Length  = 4'd3;
        bus.i_Start   = 1'b1;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Start = 1'b0;
        rst         = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("start_reset", c, observe(), 10'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_sequence_player.md
Name: led_sequence_player

Overview:
Controller that plays a latched sequence of 2-bit LED codes onto the 4 board LEDs with fixed off/on timing. It is started by the game controller with a start pulse. It reports completion with a one-cycle done pulse. It replaces the free-running toggle-counter approach with an explicit start/busy/done handshake and abort. Top level ORs its LED outputs with the debounced switch echoes.

Parameters:
CLKS_PER_STEP, 6250000, clock cycles for each OFF phase and each ON phase (default is 1/4 s at 25 MHz); must be >= 2.
MAX_LEN, 11, maximum number of sequence entries; i_Pattern is 2*MAX_LEN bits wide.

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Start  in  1  start request; sampled only in IDLE
i_Abort  in  1  abandon playback; effective in any busy state
i_Length  in  4  number of entries to play (0..15, clamped to MAX_LEN)
i_Pattern  in  2*MAX_LEN  entry k = i_Pattern[2k+1:2k]
o_Busy  out  1  high while playing (OFF/ON states)
o_Done  out  1  one-cycle pulse after the last entry's ON phase
o_Index  out  4  entry currently being played; 0 when idle
o_LED_1..o_LED_4  out  1 each  one-hot LED drive; code 00->LED_1, 01->LED_2, 10->LED_3, 11->LED_4

Behaviour:
- Reset is synchronous and active-high. The clock is i_Clk and the reset is i_Reset.
- Reset values: state=IDLE, o_Busy=0, o_Done=0, o_Index=0, all LEDs=0, step counter=0.
- Reset mid-playback: return to IDLE on the next edge. No o_Done is produced.
- States: IDLE, OFF, ON, DONE.
- IDLE:
  - On an edge with i_Start=1, latch i_Pattern and the effective length L = min(i_Length, MAX_LEN).
  - If L=0, go to DONE. Otherwise go to OFF with index=0 and counter=0.
  - o_Busy is 1 from the cycle after the accepting edge.
- OFF: LEDs all 0. The counter counts 0..CLKS_PER_STEP-1. At terminal count, clear the counter and go to ON.
- ON:
  - Exactly one LED is high, selected by the latched entry[index].
  - At terminal count with index == L-1, go to DONE.
  - At terminal count otherwise, increment index and go to OFF.
- DONE: o_Done=1 and o_Busy=0 for exactly one cycle, LEDs 0. Next state is IDLE. i_Start is ignored in DONE.
- Timing: with L>=1, o_Busy stays high for exactly 2*CLKS_PER_STEP*L cycles. o_Done is asserted in the cycle immediately after o_Busy falls.
- Latched pattern and length are not affected by i_Pattern/i_Length changes during playback.
- i_Start while busy or in DONE is ignored. It is not queued.
- i_Abort:
  - In OFF or ON, i_Abort=1 forces IDLE on the next edge, with LEDs 0, o_Index 0 and no o_Done.
  - i_Abort in IDLE/DONE has no effect.
  - i_Start and i_Abort both high in IDLE: start wins; abort is not considered until the next cycle.
- Counter width is $clog2(CLKS_PER_STEP). The counter never wraps past the terminal count.
- Index width is 4 bits. Index never exceeds L-1.
- o_Index equals the internal index in OFF/ON and is 0 otherwise.
- LED outputs are registered or decoded from registered state only, with no combinational path from inputs. At most one LED is high in any cycle.

Test Plan:
- Reset/idle: assert i_Reset for 3 cycles, then hold 20 cycles with no start. Required: o_Busy=0, o_Done=0, o_Index=0, all LEDs 0 throughout.
- Basic play (CLKS_PER_STEP=4): i_Pattern entries {0:2'b10, 1:2'b01, 2:2'b11}, i_Length=3, one-cycle i_Start.
  - o_Busy high for 24 cycles, then o_Done high 1 cycle.
  - LED_3 high cycles 5-8, LED_2 high cycles 13-16, LED_4 high cycles 21-24 (busy cycles numbered 1-24).
  - o_Index reads 0, 1, 2 across the three entries.
- Boundaries:
  - i_Length=0 -> o_Done pulses the cycle after the start edge, o_Busy never rises, no LED lights.
  - i_Length=15 -> exactly 11 entries are played; o_Busy is high 88 cycles.
- Ignored start and input changes: with i_Length=2, pulse i_Start again in busy cycle 10 and change i_Pattern/i_Length mid-play. Required: playback unchanged, a single o_Done, and the second start is not replayed afterwards.
- Abort: assert i_Abort during the ON phase of entry 1. Required: next cycle o_Busy=0, all LEDs 0, o_Index=0, and no o_Done in the following 30 cycles. A subsequent i_Start plays normally from entry 0.
- Mid-operation reset: assert i_Reset in busy cycle 7 with i_Abort=0. Required: IDLE next cycle and all outputs at reset values. A simultaneous i_Start and i_Reset leaves the block idle.
